oversampling_period_generator: RTL and testbench
================================================

Name: oversampling_period_generator

Overview:
- Transmit-side counterpart of oversampling_period_measure: synthesizes a square wave with sub-clock period resolution.
- Emits one parallel word of 2^OVERSAMPLING_BITS subsamples per CLK, to be serialized by an OSERDES at the shift clock.
- Used for the theremin reference oscillator, and as loopback stimulus into the measurement path.
- Half-period is programmed in subsample ticks. Updates are glitch-free and take effect only at waveform edges.

Parameters:
- COUNTER_BITS, 16: integer part width of half-period (whole CLK cycles).
- OVERSAMPLING_BITS, 3: log2 subsamples per CLK (0..3); N = 2^OVERSAMPLING_BITS.
- DEFAULT_HALF_PERIOD, 1000: half-period in subsample ticks, active after reset.

Ports:
- CLK, in, 1: parallel clock (200MHz); all logic is on this edge.
- RESETN, in, 1: asynchronous, active-low reset.
- EN, in, 1: generator enable.
- CFG_HALF_PERIOD, in, COUNTER_BITS+OVERSAMPLING_BITS: new half-period in subsample ticks.
- CFG_VALID, in, 1: configuration offer.
- CFG_READY, out, 1: configuration slot free.
- OUT_WORD, out, N: subsamples for this CLK; bit 0 is transmitted first.
- EDGE_FLAG, out, 1: one-cycle pulse; OUT_WORD contains a rising edge.
- EDGE_POS, out, OVERSAMPLING_BITS: subsample index of that rising edge; valid while EDGE_FLAG=1.

Behaviour:
- Internal state:
  - level: current output level.
  - rem: subsample offset of next toggle relative to current word start; width COUNTER_BITS+OVERSAMPLING_BITS+1.
  - active_h: half-period in use.
  - pending_h / pending_v: one-entry configuration slot.
- Reset values:
  - OUT_WORD=0, EDGE_FLAG=0, EDGE_POS=0, level=0.
  - active_h=DEFAULT_HALF_PERIOD, rem=active_h, pending_v=0, CFG_READY=1.
- Clamp: any half-period < N, including 0, is used as N. This guarantees at most one toggle per word.
- Handshake:
  - CFG_READY = !pending_v.
  - Transfer occurs when CFG_VALID && CFG_READY; the clamped value goes to pending_h and pending_v is set.
  - While pending_v=1, offers are not accepted.
- States:
  - IDLE (EN=0): OUT_WORD=0, EDGE_FLAG=0, level=0.
  - IDLE: if pending_v, active_h<=pending_h and pending_v clears; rem<=active_h in use next.
  - RUN (EN=1): word generation as below.
- Word generation per CLK in RUN, registered (1-cycle latency):
  - If rem >= N: OUT_WORD = all bits level; rem <= rem - N.
  - If rem < N: bits [0..rem-1] = level, bits [rem..N-1] = ~level; level toggles.
  - In the toggle case, h_next = pending_v ? pending_h : active_h. Then rem <= rem + h_next - N and active_h <= h_next, and pending_v clears if used.
  - If the toggle is rising (level was 0): EDGE_FLAG=1 and EDGE_POS=rem. Otherwise EDGE_FLAG=0.
- EN 0->1 at CLK edge t: word at t+1 is the first RUN word. Output starts low; first rise is at subsample active_h from that word's start.
- EN 1->0 mid-period: next word is 0, and state drops to IDLE semantics. The pending slot is retained and applied on re-enable.
- Simultaneous accept and toggle in the same cycle: the current toggle uses the old slot contents. The newly accepted value applies at the following toggle.
- Arithmetic: no wrap. rem + h_next - N >= 0 always holds because of the clamp. The one extra rem bit covers the max-value sum.
- RESETN asserted mid-operation: all state returns to reset values immediately, regardless of CLK. The pending offer is discarded.

Decomposition:
- Shared package oversampling_pkg:
  - Constants N and DURATION_BITS (= COUNTER_BITS+OVERSAMPLING_BITS).
  - Typedef duration_t.
  - Function clamp_half_period.
  - The same package is also imported by oversampling_period_measure.
- One sub-module oversampling_word_builder: combinational word from (level, rem<N, rem[OVERSAMPLING_BITS-1:0]) producing OUT_WORD and the edge position. The top module keeps all state.

Test Plan (OVERSAMPLING_BITS=3, N=8):
- Basic: H=20, EN rises.
  - Required words from first RUN word: 00,00,F0,FF,FF,00,00,F0.
  - EDGE_FLAG high on words 2 and 7 with EDGE_POS=4.
  - Period = 40 subsamples.
- Clamp: H=3 offered.
  - Toggles every word after the first: 00 then FF,00,FF,...
  - EDGE_POS=0 on each FF word.
- Update timing: running at H=20, offer H=12 two cycles before a toggle.
  - CFG_READY drops for exactly the cycles until that toggle.
  - The next half-period measures 12 subsamples, and no runt pulse appears.
- Simultaneous: offer H=16 in the same cycle as a toggle.
  - The next half uses the old H=20; the half after uses 16.
- Enable/reset: drop EN mid-high-phase.
  - Next word is 00; re-enable restarts low with a full first half.
  - Asserting RESETN low between CLK edges clears OUT_WORD and CFG_READY=1 immediately.
- Loopback: feed serialized output into oversampling_period_measure with H=17159.
  - DURATION reads 34318 (2H) for every period after settling.

Source files
------------

// File: rtl/oversampling_pkg.sv
// Constants, types and helpers shared by the oversampling period generator and measure blocks.
package oversampling_pkg;

  localparam int DEFAULT_COUNTER_BITS      = 16;
  localparam int DEFAULT_OVERSAMPLING_BITS = 3;
  localparam int N                         = 1 << DEFAULT_OVERSAMPLING_BITS;
  localparam int DURATION_BITS             = DEFAULT_COUNTER_BITS + DEFAULT_OVERSAMPLING_BITS;

  typedef logic [DURATION_BITS-1:0] duration_t;

  // A half-period shorter than one word would need two toggles inside a single word.
  function automatic logic [31:0] clamp_half_period(input logic [31:0] h, input int unsigned n);
    return (h < n) ? n : h;
  endfunction

endpackage

// File: rtl/oversampling_word_builder.sv
// Builds one parallel word of subsamples: the current level up to the toggle index, the inverse after it.
module oversampling_word_builder
  import oversampling_pkg::*;
#(
  parameter int OVERSAMPLING_BITS = DEFAULT_OVERSAMPLING_BITS
) (
  input  logic                                level,
  input  logic                                toggle,
  input  logic [OVERSAMPLING_BITS-1:0]        pos,
  output logic [(1 << OVERSAMPLING_BITS)-1:0] word,
  output logic [OVERSAMPLING_BITS-1:0]        edge_pos
);

  localparam int NS = 1 << OVERSAMPLING_BITS;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_bit
      assign word[gi] = (toggle && (pos <= OVERSAMPLING_BITS'(gi))) ? ~level : level;
    end
  endgenerate

  assign edge_pos = pos;

endmodule

// File: rtl/oversampling_period_generator.sv
// Square-wave synthesizer with sub-clock resolution; emits one word of subsamples per CLK for an OSERDES.
module oversampling_period_generator
  import oversampling_pkg::*;
#(
  parameter int COUNTER_BITS        = DEFAULT_COUNTER_BITS,
  parameter int OVERSAMPLING_BITS   = DEFAULT_OVERSAMPLING_BITS,
  parameter int DEFAULT_HALF_PERIOD = 1000
) (
  input  logic                                   CLK,
  input  logic                                   RESETN,
  input  logic                                   EN,
  input  logic [COUNTER_BITS+OVERSAMPLING_BITS-1:0] CFG_HALF_PERIOD,
  input  logic                                   CFG_VALID,
  output logic                                   CFG_READY,
  output logic [(1 << OVERSAMPLING_BITS)-1:0]    OUT_WORD,
  output logic                                   EDGE_FLAG,
  output logic [OVERSAMPLING_BITS-1:0]           EDGE_POS
);

  localparam int NS = 1 << OVERSAMPLING_BITS;
  localparam int DW = COUNTER_BITS + OVERSAMPLING_BITS;
  localparam logic [DW-1:0] DEFAULT_H = DW'(clamp_half_period(32'(DEFAULT_HALF_PERIOD), NS));
  localparam logic [DW:0]   NS_W      = (DW+1)'(NS);

  logic          level_reg;
  logic [DW:0]   rem_reg;
  logic [DW-1:0] active_h_reg;
  logic [DW-1:0] pending_h_reg;
  logic          pending_v_reg;
  logic [NS-1:0] out_word_reg;
  logic          edge_flag_reg;
  logic [OVERSAMPLING_BITS-1:0] edge_pos_reg;

  logic          toggle;
  logic          accept;
  logic [DW-1:0] cfg_clamped;
  logic [DW-1:0] h_next;
  logic [DW:0]   rem_toggle_next;
  logic [DW:0]   rem_plain_next;
  logic [NS-1:0] word_next;
  logic [OVERSAMPLING_BITS-1:0] pos_next;

  assign toggle          = rem_reg < NS_W;
  assign accept          = CFG_VALID && !pending_v_reg;
  assign cfg_clamped     = DW'(clamp_half_period(32'(CFG_HALF_PERIOD), NS));
  assign h_next          = pending_v_reg ? pending_h_reg : active_h_reg;
  // Cannot underflow: rem < N at a toggle and h_next >= N after clamping.
  assign rem_toggle_next = rem_reg + {1'b0, h_next} - NS_W;
  assign rem_plain_next  = rem_reg - NS_W;

  oversampling_word_builder #(
    .OVERSAMPLING_BITS(OVERSAMPLING_BITS)
  ) u_word_builder (
    .level   (level_reg),
    .toggle  (toggle),
    .pos     (rem_reg[OVERSAMPLING_BITS-1:0]),
    .word    (word_next),
    .edge_pos(pos_next)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      level_reg     <= 1'b0;
      rem_reg       <= {1'b0, DEFAULT_H};
      active_h_reg  <= DEFAULT_H;
      pending_h_reg <= DEFAULT_H;
      pending_v_reg <= 1'b0;
      out_word_reg  <= '0;
      edge_flag_reg <= 1'b0;
      edge_pos_reg  <= '0;
    end else begin
      if (!EN) begin
        out_word_reg  <= '0;
        edge_flag_reg <= 1'b0;
        level_reg     <= 1'b0;
        pending_v_reg <= 1'b0;
        if (pending_v_reg) begin
          active_h_reg <= pending_h_reg;
          rem_reg      <= {1'b0, pending_h_reg};
        end else begin
          rem_reg      <= {1'b0, active_h_reg};
        end
      end else begin
        out_word_reg <= word_next;
        if (toggle) begin
          level_reg     <= ~level_reg;
          rem_reg       <= rem_toggle_next;
          active_h_reg  <= h_next;
          pending_v_reg <= 1'b0;
          edge_flag_reg <= ~level_reg;
          if (!level_reg) begin
            edge_pos_reg <= pos_next;
          end
        end else begin
          rem_reg       <= rem_plain_next;
          edge_flag_reg <= 1'b0;
        end
      end
      // An accept only happens with the slot empty, so it never collides with a slot clear.
      if (accept) begin
        pending_h_reg <= cfg_clamped;
        pending_v_reg <= 1'b1;
      end
    end
  end

  assign CFG_READY = !pending_v_reg;
  assign OUT_WORD  = out_word_reg;
  assign EDGE_FLAG = edge_flag_reg;
  assign EDGE_POS  = edge_pos_reg;

endmodule

// File: tb/tb_oversampling_period_generator.sv
// Directed bench for oversampling_period_generator with N=8 subsamples per word.
module tb_oversampling_period_generator;

  localparam int DW = 19;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b1;
  logic          EN = 1'b0;
  logic          CFG_VALID = 1'b0;
  logic [DW-1:0] CFG_HALF_PERIOD = '0;
  logic          CFG_READY;
  logic [7:0]    OUT_WORD;
  logic          EDGE_FLAG;
  logic [2:0]    EDGE_POS;

  int n_cmp = 0;
  int n_err = 0;

  oversampling_period_generator #(
    .COUNTER_BITS(16),
    .OVERSAMPLING_BITS(3),
    .DEFAULT_HALF_PERIOD(1000)
  ) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .EN             (EN),
    .CFG_HALF_PERIOD(CFG_HALF_PERIOD),
    .CFG_VALID      (CFG_VALID),
    .CFG_READY      (CFG_READY),
    .OUT_WORD       (OUT_WORD),
    .EDGE_FLAG      (EDGE_FLAG),
    .EDGE_POS       (EDGE_POS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          en;
    logic          cfg_v;
    logic [DW-1:0] cfg_h;
    logic [7:0]    word;
    logic          flag;
    logic [2:0]    pos;
    logic          ready;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic en, input logic cv, input int h, input logic [7:0] w,
                     input logic f, input logic [2:0] p, input logic r);
    vq.push_back('{en, cv, DW'(h), w, f, p, r});
  endtask

  initial begin
    int w;
    int first_abs;
    int prev_abs;
    int rises;
    bit found;

    // Basic H=20
    add(1,0,0,8'h00,0,0,1); add(1,0,0,8'h00,0,0,1); add(1,0,0,8'hF0,1,4,1);
    add(1,0,0,8'hFF,0,0,1); add(1,0,0,8'hFF,0,0,1); add(1,0,0,8'h00,0,0,1);
    add(1,0,0,8'h00,0,0,1); add(1,0,0,8'hF0,1,4,1);
    // Offer H=12 two cycles ahead of the falling toggle
    add(1,1,12,8'hFF,0,0,0); add(1,0,0,8'hFF,0,0,0); add(1,0,0,8'h00,0,0,1);
    add(1,0,0,8'hF0,1,4,1); add(1,0,0,8'hFF,0,0,1); add(1,0,0,8'h00,0,0,1);
    // Offer H=20 on a toggle: next half still 12, then 20
    add(1,1,20,8'hF0,1,4,0); add(1,0,0,8'hFF,0,0,0); add(1,0,0,8'h00,0,0,1);
    add(1,0,0,8'h00,0,0,1); add(1,0,0,8'hF0,1,4,1); add(1,0,0,8'hFF,0,0,1);
    add(1,0,0,8'hFF,0,0,1);
    // Offer H=16 on a toggle: next half uses 20, then 16
    add(1,1,16,8'h00,0,0,0); add(1,0,0,8'h00,0,0,0); add(1,0,0,8'hF0,1,4,1);
    add(1,0,0,8'hFF,0,0,1); add(1,0,0,8'h0F,0,0,1); add(1,0,0,8'h00,0,0,1);
    add(1,0,0,8'hF0,1,4,1);
    // Offer H=3 (clamped to 8), drop EN mid-high, re-enable
    add(1,1,3,8'hFF,0,0,0); add(0,0,0,8'h00,0,0,1); add(0,0,0,8'h00,0,0,1);
    add(1,0,0,8'h00,0,0,1); add(1,0,0,8'hFF,1,0,1); add(1,0,0,8'h00,0,0,1);
    add(1,0,0,8'hFF,1,0,1); add(1,0,0,8'h00,0,0,1);

    // Asynchronous reset before any clock edge
    #2 RESETN = 1'b0;
    #1;
    check("reset OUT_WORD", 32'(OUT_WORD), 32'h00);
    check("reset EDGE_FLAG", 32'(EDGE_FLAG), 32'h0);
    check("reset EDGE_POS", 32'(EDGE_POS), 32'h0);
    check("reset CFG_READY", 32'(CFG_READY), 32'h1);
    step(); step();
    RESETN = 1'b1;

    CFG_VALID = 1'b1;
    CFG_HALF_PERIOD = DW'(20);
    step();
    CFG_VALID = 1'b0;
    check("idle accept READY", 32'(CFG_READY), 32'h0);
    step();
    check("idle apply READY", 32'(CFG_READY), 32'h1);
    check("idle OUT_WORD", 32'(OUT_WORD), 32'h00);

    for (int i = 0; i < vq.size(); i++) begin
      EN = vq[i].en;
      CFG_VALID = vq[i].cfg_v;
      CFG_HALF_PERIOD = vq[i].cfg_h;
      step();
      $display("vec %0d en=%0d cfg_v=%0d h=%0d word=%02h flag=%0d pos=%0d ready=%0d",
               i, vq[i].en, vq[i].cfg_v, vq[i].cfg_h, OUT_WORD, EDGE_FLAG, EDGE_POS, CFG_READY);
      check($sformatf("v%0d word", i), 32'(OUT_WORD), 32'(vq[i].word));
      check($sformatf("v%0d flag", i), 32'(EDGE_FLAG), 32'(vq[i].flag));
      check($sformatf("v%0d ready", i), 32'(CFG_READY), 32'(vq[i].ready));
      if (vq[i].flag) check($sformatf("v%0d pos", i), 32'(EDGE_POS), 32'(vq[i].pos));
    end
    CFG_VALID = 1'b0;

    // Mid-run reset between edges with an offer pending
    CFG_VALID = 1'b1;
    CFG_HALF_PERIOD = DW'(40);
    step();
    CFG_VALID = 1'b0;
    check("pre-reset word", 32'(OUT_WORD), 32'hFF);
    check("pre-reset READY", 32'(CFG_READY), 32'h0);
    #2 RESETN = 1'b0;
    #1;
    $display("async reset: word=%02h flag=%0d ready=%0d", OUT_WORD, EDGE_FLAG, CFG_READY);
    check("async reset OUT_WORD", 32'(OUT_WORD), 32'h00);
    check("async reset EDGE_FLAG", 32'(EDGE_FLAG), 32'h0);
    check("async reset READY", 32'(CFG_READY), 32'h1);
    @(posedge CLK);
    #1 RESETN = 1'b1;

    // Default half-period of 1000 ticks: first rise in word 125 at subsample 0
    found = 1'b0;
    w = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (EDGE_FLAG) found = 1'b1;
      else w++;
    end
    $display("default first rise: word %0d pos %0d", w, EDGE_POS);
    check("default rise found", 32'(found), 32'h1);
    check("default rise word", 32'(w), 32'd125);
    check("default rise pos", 32'(EDGE_POS), 32'h0);
    check("default rise OUT_WORD", 32'(OUT_WORD), 32'hFF);

    // Long half-period: rising edges every 2H subsamples
    EN = 1'b0;
    CFG_VALID = 1'b1;
    CFG_HALF_PERIOD = DW'(17159);
    step();
    CFG_VALID = 1'b0;
    step();
    EN = 1'b1;
    rises = 0;
    first_abs = 0;
    prev_abs = 0;
    for (int k = 0; k < 20000 && rises < 4; k++) begin
      step();
      if (EDGE_FLAG) begin
        int abs_pos;
        abs_pos = k * 8 + int'(EDGE_POS);
        $display("loopback rise %0d at subsample %0d", rises, abs_pos);
        if (rises == 0) first_abs = abs_pos;
        else check($sformatf("loopback period %0d", rises), 32'(abs_pos - prev_abs), 32'd34318);
        prev_abs = abs_pos;
        rises++;
      end
    end
    check("loopback rise count", 32'(rises), 32'd4);
    check("loopback first rise", 32'(first_abs), 32'd17159);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
